// File: rtl/spi_sram_pkg.sv
// Shared opcodes, widths, FSM state encoding and request record for the SPI SRAM master.
package spi_sram_pkg;
  localparam logic [7:0] SPI_SRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_SRAM_CMD_WRITE = 8'h02;
  localparam int         SPI_SRAM_ADDR_W    = 24;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} spi_master_state_t;

  typedef struct packed {
    logic                       wr;
    logic [SPI_SRAM_ADDR_W-1:0] addr;
    logic [7:0]                 wdata;
  } spi_req_t;

  function automatic logic [7:0] spi_opcode(input logic wr);
    return wr ? SPI_SRAM_CMD_WRITE : SPI_SRAM_CMD_READ;
  endfunction
endpackage

// File: rtl/spi_sram_master_if.sv
// Host-side request/response bus of the SPI SRAM master.
interface spi_sram_master_if;
  import spi_sram_pkg::*;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_wr;
  logic [SPI_SRAM_ADDR_W-1:0] req_addr;
  logic [7:0]                 req_wdata;
  logic                       rsp_valid;
  logic [7:0]                 rsp_rdata;
  logic                       busy;

  modport master (output req_valid, req_wr, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, busy);
  modport slave  (input  req_valid, req_wr, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/spi_sram_master_sclk_gen.sv
// SCLK generator: toggles every CLK_DIV clk while enabled, always restarts from low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick     = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = tick && !sclk;
  assign fall_stb = tick && sclk;

  // Half-period counter; disabling clears both counter and level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_sram_master.sv
// SPI mode-0 master turning byte requests into SRAM READ/WRITE frames, merging
// sequential requests into a single CS-low burst.
module spi_sram_master
  import spi_sram_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_sram_master_if.slave host,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  localparam int WW = $clog2(CS_HIGH_CYC + CLK_DIV + 1);

  spi_master_state_t          state, state_nxt;
  spi_req_t                   cur;
  logic [SPI_SRAM_ADDR_W-1:0] next_addr;
  logic [4:0]                 bit_cnt;
  logic [7:0]                 tx, rx, rsp_rdata_q;
  logic [WW-1:0]              wcnt;
  logic rise_stb, fall_stb, sclk_en, phase_last, rdy, accept, done_pend, rsp_valid_q;

  assign sclk_en    = state inside {CMD, ADDR, DATA};
  assign phase_last = fall_stb && (bit_cnt == ((state == ADDR) ? 5'd23 : 5'd7));
  assign accept     = host.req_valid && rdy;

  assign host.req_ready = rdy;
  assign host.busy      = (state != IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign spi_cs_n       = (state == IDLE) || (state == DESEL);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst(rst), .en(sclk_en),
    .sclk(spi_sclk), .rise_stb(rise_stb), .fall_stb(fall_stb)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and accept; in HOLD only a request continuing the burst is taken.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (host.req_valid) state_nxt = CMD;
      end
      CMD:  if (phase_last) state_nxt = ADDR;
      ADDR: if (phase_last) state_nxt = DATA;
      DATA: if (phase_last) state_nxt = HOLD;
      HOLD: begin
        rdy = host.req_valid && (host.req_wr == cur.wr) && (host.req_addr == next_addr);
        if (rdy)                               state_nxt = DATA;
        else if (wcnt == WW'(CLK_DIV - 1))     state_nxt = DESEL;
      end
      DESEL: if (wcnt == WW'(CS_HIGH_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial data out: opcode, then address MSB-first, then write data (0 on reads).
  always_comb begin
    spi_mosi = 1'b0;
    case (state)
      CMD:     spi_mosi = tx[7];
      ADDR:    spi_mosi = cur.addr[5'd23 - bit_cnt];
      DATA:    spi_mosi = cur.wr & tx[7];
      default: spi_mosi = 1'b0;
    endcase
  end

  // Request latch, bit counter and transmit shifter; bits advance on SCLK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      next_addr <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur.wr    <= host.req_wr;
          cur.addr  <= host.req_addr;
          cur.wdata <= host.req_wdata;
          next_addr <= host.req_addr + 1'b1;
          tx        <= spi_opcode(host.req_wr);
          bit_cnt   <= '0;
        end
        CMD, ADDR, DATA: if (fall_stb) begin
          bit_cnt <= phase_last ? 5'd0 : bit_cnt + 5'd1;
          tx      <= (state == ADDR && phase_last) ? cur.wdata : {tx[6:0], 1'b0};
        end
        HOLD: if (accept) begin
          tx        <= host.req_wdata;
          next_addr <= next_addr + 1'b1;
          bit_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Receive shifter and response pulse one clk after the 8th data rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx          <= '0;
      done_pend   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (state == DATA && rise_stb) rx <= {rx[6:0], spi_miso};
      done_pend   <= (state == DATA) && rise_stb && (bit_cnt == 5'd7);
      rsp_valid_q <= done_pend;
      if (done_pend && !cur.wr) rsp_rdata_q <= rx;
    end
  end

  // Shared dwell counter for HOLD timeout and DESEL chip-select high time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wcnt <= '0;
    else if (state_nxt != state)               wcnt <= '0;
    else if (state == HOLD || state == DESEL)  wcnt <= wcnt + 1'b1;
  end
endmodule

// File: tb/tb_spi_sram_master.sv
// Scoreboard bench: randomized and directed host traffic against an SPI SRAM
// responder model with a byte memory; frame shape derived from the burst rules.
module tb_spi_sram_master;
  import spi_sram_pkg::*;

  localparam int CLK_DIV     = 2;
  localparam int CS_HIGH_CYC = 8;
  localparam int LAT         = 1 + 39*2*CLK_DIV + CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk, spi_cs_n, spi_mosi;
  logic spi_miso = 1'b0;
  int   cyc = 0;

  spi_sram_master_if ifc();

  spi_sram_master #(.CLK_DIV(CLK_DIV), .CS_HIGH_CYC(CS_HIGH_CYC)) dut (
    .clk(clk), .rst(rst), .host(ifc),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder memory and reference memory.
  logic [7:0] smem [logic [23:0]];
  logic [7:0] rmem [logic [23:0]];
  function automatic logic [7:0] rd_s(input logic [23:0] a);
    return smem.exists(a) ? smem[a] : 8'h00;
  endfunction
  function automatic logic [7:0] rd_r(input logic [23:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  // Scoreboard.
  typedef struct { logic wr; logic [7:0] data; bit lat_chk; int acc_cyc; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst && ifc.rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.wr)     chk("rd_data", ifc.rsp_rdata, e.data);
        if (e.lat_chk) chk("latency", cyc - e.acc_cyc, LAT);
      end
    end
  end

  // SPI SRAM responder and frame observer.
  logic       sclk_q = 1'b0, cs_q = 1'b1;
  int         s_bits = 0, win_r = 0, hi_cnt = 0, mosi_bad = 0;
  bit         have_prev = 0, skip_hi = 0;
  logic [7:0] s_op, s_sh, tmp;
  logic [23:0] s_addr;
  int         win_rises[$];
  logic [7:0] ops[$];
  logic [23:0] adrs[$];

  always @(negedge clk) begin
    if (cs_q && !spi_cs_n) begin
      if (have_prev && !skip_hi) begin
        checks++;
        if (hi_cnt < CS_HIGH_CYC) begin
          errors++;
          $display("FAIL cs_high_min: got %0d cycles need >= %0d", hi_cnt, CS_HIGH_CYC);
        end
      end
      skip_hi = 0; s_bits = 0; win_r = 0;
    end
    if (!cs_q && spi_cs_n) begin
      win_rises.push_back(win_r);
      have_prev = 1; hi_cnt = 0;
    end
    if (spi_cs_n) hi_cnt++;
    else begin
      if (spi_sclk && !sclk_q) begin
        win_r++;
        if (s_bits < 8) s_op = {s_op[6:0], spi_mosi};
        else if (s_bits < 32) s_addr = {s_addr[22:0], spi_mosi};
        else begin
          if (s_op == 8'h03 && spi_mosi) mosi_bad++;
          s_sh = {s_sh[6:0], spi_mosi};
          if (((s_bits - 32) % 8) == 7) begin
            if (s_op == 8'h02) smem[s_addr] = s_sh;
            s_addr = s_addr + 24'd1;
          end
        end
        s_bits++;
        if (s_bits == 8)  ops.push_back(s_op);
        if (s_bits == 32) adrs.push_back(s_addr);
      end
      if (!spi_sclk && sclk_q && s_bits >= 32) begin
        tmp = rd_s(s_addr);
        spi_miso = (s_op == 8'h03) ? tmp[7 - ((s_bits - 32) % 8)] : 1'b0;
      end
    end
    sclk_q = spi_sclk;
    cs_q   = spi_cs_n;
  end

  // Expected frame shape from the burst rule.
  bit          chain = 0, lat_next = 0;
  logic        pwr;
  logic [23:0] paddr;
  int          exp_rises[$];
  logic [7:0]  exp_ops[$];
  logic [23:0] exp_adrs[$];

  task automatic issue(input logic wr, input logic [23:0] a, input logic [7:0] d);
    exp_t e;
    int   n = 0;
    ifc.req_valid = 1'b1; ifc.req_wr = wr; ifc.req_addr = a; ifc.req_wdata = d;
    #1;
    while (!ifc.req_ready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      chk("accept_timeout", 32'd0, 32'd1);
      ifc.req_valid = 1'b0;
      return;
    end
    e.wr = wr; e.data = wr ? d : rd_r(a); e.lat_chk = lat_next; e.acc_cyc = cyc;
    sb.push_back(e);
    lat_next = 0;
    if (wr) rmem[a] = d;
    if (chain && wr == pwr && a == paddr + 24'd1)
      exp_rises[exp_rises.size()-1] = exp_rises[exp_rises.size()-1] + 8;
    else begin
      exp_rises.push_back(40);
      exp_ops.push_back(wr ? 8'h02 : 8'h03);
      exp_adrs.push_back(a);
    end
    chain = 1; pwr = wr; paddr = a;
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((ifc.busy || sb.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_obs();
    win_rises.delete(); ops.delete(); adrs.delete();
    exp_rises.delete(); exp_ops.delete(); exp_adrs.delete();
    chain = 0;
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_windows"}, win_rises.size(), exp_rises.size());
    foreach (exp_rises[i]) if (i < win_rises.size()) chk({tag, "_rises"}, win_rises[i], exp_rises[i]);
    foreach (exp_ops[i])   if (i < ops.size())       chk({tag, "_opcode"}, ops[i], exp_ops[i]);
    foreach (exp_adrs[i])  if (i < adrs.size())      chk({tag, "_addr"}, adrs[i], exp_adrs[i]);
    chk({tag, "_rsp_drained"}, sb.size(), 0);
    clear_obs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, k;
    logic        wr;
    logic [23:0] a;
    ifc.req_valid = 1'b0; ifc.req_wr = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_rsp_rdata", ifc.rsp_rdata, 0);
    chk("rst_busy", ifc.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write with latency check.
    lat_next = 1;
    issue(1'b1, 24'h012345, 8'hA5);
    wait_idle(); check_frames("t1");
    chk("t1_mem", rd_s(24'h012345), 8'hA5);

    // Single read.
    smem[24'h000010] = 8'h5A; rmem[24'h000010] = 8'h5A;
    issue(1'b0, 24'h000010, 8'h00);
    wait_idle(); check_frames("t2");
    chk("t2_read_mosi_low", mosi_bad, 0);

    // Sequential writes across a 64K boundary merge.
    issue(1'b1, 24'h00FFFF, 8'h11);
    issue(1'b1, 24'h010000, 8'h22);
    wait_idle(); check_frames("t3");
    chk("t3_mem0", rd_s(24'h00FFFF), 8'h11);
    chk("t3_mem1", rd_s(24'h010000), 8'h22);

    // Direction change breaks the burst.
    issue(1'b0, 24'h000100, 8'h00);
    issue(1'b1, 24'h000101, 8'h33);
    wait_idle(); check_frames("t4");
    chk("t4_mem", rd_s(24'h000101), 8'h33);

    // Read burst across the address wrap.
    smem[24'hFFFFFF] = 8'hC3; rmem[24'hFFFFFF] = 8'hC3;
    smem[24'h000000] = 8'h3C; rmem[24'h000000] = 8'h3C;
    issue(1'b0, 24'hFFFFFF, 8'h00);
    issue(1'b0, 24'h000000, 8'h00);
    wait_idle(); check_frames("t5");

    // Reset in the middle of the address phase.
    issue(1'b0, 24'h000020, 8'h00);
    n = 0;
    while (s_bits < 20 && n < 1000) begin @(negedge clk); n++; end
    chk("t6_reach_addr", (s_bits >= 20), 1);
    rst = 1'b1;
    #1;
    chk("t6_cs_n", spi_cs_n, 1);
    chk("t6_sclk", spi_sclk, 0);
    sb.delete();
    skip_hi = 1;
    repeat (3) @(negedge clk);
    chk("t6_busy", ifc.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    clear_obs();
    issue(1'b1, 24'h000030, 8'h77);
    wait_idle();
    issue(1'b0, 24'h000030, 8'h00);
    wait_idle(); check_frames("t6");

    // Randomized groups of back-to-back requests.
    for (int g = 0; g < 12; g++) begin
      n  = $urandom_range(1, 5);
      wr = 1'($urandom_range(0, 1));
      a  = 24'($urandom_range(0, 63));
      for (k = 0; k < n; k++) begin
        issue(wr, a, 8'($urandom));
        if ($urandom_range(0, 2) != 0) a = a + 24'd1;
        else begin
          wr = 1'($urandom_range(0, 1));
          a  = 24'($urandom_range(0, 63));
        end
      end
      wait_idle(); check_frames("rnd");
    end
    chk("read_mosi_low", mosi_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
